pipe_shifter: RTL and testbench
===============================

PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 Parameter W, default 32: data width; power of two, 8..64.
REQ-002 Parameter STAGES, default 2: pipeline register stages; 1..$clog2(W).
REQ-003 Parameter TAGW, default 4: width of the sideband tag carried alongside data.
REQ-004 Reset is synchronous and active-low; the block has one clock.
REQ-005 s_clk_i  input  1  clock; all state updates on rising edge.
REQ-006 s_resetn_i  input  1  synchronous active-low reset.
REQ-007 s_flush_i  input  1  discard all in-flight operations.
REQ-008 s_valid_i  input  1  request valid.
REQ-009 s_ready_o  output  1  block can accept a request this cycle.
REQ-010 s_op_i  input  2  operation, type shift_op_t: SLL, SRL, SRA, ROR.
REQ-011 s_amt_i  input  $clog2(W)  shift amount.
REQ-012 s_data_i  input  W  operand.
REQ-013 s_tag_i  input  TAGW  sideband tag, returned unmodified.
REQ-014 s_valid_o  output  1  result valid.
REQ-015 s_ready_i  input  1  consumer accepts result.
REQ-016 s_data_o  output  W  result.
REQ-017 s_tag_o  output  TAGW  tag of the result.

Function
REQ-018 A transfer occurs on a clock edge where valid and ready are both high; input and output sides are handled independently.
REQ-019 Amount bits are partitioned into STAGES groups of B=ceil($clog2(W)/STAGES) bits, LSB group first; stage k applies bits [k*B, min((k+1)*B,$clog2(W))-1]; the final group may be narrower.
REQ-020 SLL fills vacated bits with 0; SRL fills with 0; SRA fills with bit W-1 of the original operand, carried through all stages; ROR rotates right by s_amt_i.
REQ-021 Amount 0 returns s_data_i unchanged for every op.
REQ-022 Latency with s_ready_i high is exactly STAGES cycles from input transfer to s_valid_o high; throughput one result per cycle.
REQ-023 Each stage holds one entry; a stage loads when it is empty or its entry advances this cycle (elastic pipeline, no bubbles required).
REQ-024 s_ready_o = stage 0 empty or stage 0 advancing; it depends combinationally on s_ready_i only through the stage-advance chain, never on s_valid_i.
REQ-025 While s_valid_o is high and s_ready_i low, s_data_o and s_tag_o hold stable.
REQ-026 Results leave in acceptance order; none is dropped or duplicated under any s_ready_i pattern.
REQ-027 s_flush_i high clears every stage valid bit at that edge; a request presented in the same cycle is discarded; s_valid_o is low the following cycle.
REQ-028 s_ready_o is high during a flush cycle.

Reset
REQ-029 At a rising edge with s_resetn_i low, all stage valid bits clear; s_valid_o is 0 and s_ready_o is 1 from the next cycle.
REQ-030 Data and tag registers are not reset; s_data_o and s_tag_o are don't-care while s_valid_o is 0.
REQ-031 Reset asserted mid-operation discards in-flight entries with no output transfer.

Structure
REQ-032 shift_op_t (SLL=0, SRL=1, SRA=2, ROR=3) is defined in p_hardisc.
REQ-033 One sub-module pipe_shift_stage (one amount group, one register, valid/ready logic) is instantiated STAGES times via generate.
REQ-034 Right shifts and rotate need not share the left datapath; only the output behaviour is mandated.

Verification (W=32, STAGES=2, TAGW=4)
REQ-035 SLL 0x0000_0001 by 31, tag 0x5, s_ready_i=1 -> 2 cycles later s_data_o=0x8000_0000, s_tag_o=0x5.
REQ-036 SRA 0x8000_0000 by 4 -> 0xF800_0000; SRL same operand -> 0x0800_0000; ROR 0x0000_00F1 by 4 -> 0x1000_000F; any op by 0 on 0xDEAD_BEEF -> 0xDEAD_BEEF.
REQ-037 Back-to-back: 4 requests on consecutive cycles, s_ready_i=1 -> 4 results on consecutive cycles, order and tags preserved.
REQ-038 s_ready_i low 5 cycles while 4 requests are offered -> s_ready_o drops after 2 accepted; output held stable; on release all 4 delivered in order.
REQ-039 Flush with 2 entries in flight plus a concurrent request -> s_valid_o low next cycle, none of the 3 emerge; a following request completes normally in 2 cycles.
REQ-040 s_resetn_i low one cycle with entries in flight -> s_valid_o=0, s_ready_o=1 next cycle; no stale result ever appears.

Source files
------------

// File: rtl/pipe_shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package p_hardisc;

  typedef enum logic [1:0] {
    SLL = 2'd0,
    SRL = 2'd1,
    SRA = 2'd2,
    ROR = 2'd3
  } shift_op_t;

  // Amount bits handled per stage; the last stage may use fewer.
  function automatic int grp_bits(input int lw, input int stages);
    return (lw + stages - 1) / stages;
  endfunction

  // Lowest amount bit consumed by stage k.
  function automatic int grp_lo(input int k, input int b);
    return k * b;
  endfunction

  // Highest amount bit consumed by stage k, clipped to the amount width.
  function automatic int grp_hi(input int k, input int b, input int lw);
    int hi;
    hi = (k + 1) * b - 1;
    if (hi > lw - 1) hi = lw - 1;
    return hi;
  endfunction

endpackage

// File: rtl/pipe_shift_stage.sv
// One elastic pipeline stage: applies its group of amount bits to the
// operand and holds the partial result plus sideband in a single register.
module pipe_shift_stage
  import p_hardisc::*;
#(
  parameter int W    = 32,
  parameter int TAGW = 4,
  parameter int K    = 0,
  parameter int B    = 3,
  localparam int LW  = $clog2(W)
) (
  input  logic            i_clk,
  input  logic            i_resetn,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  shift_op_t       i_op,
  input  logic [LW-1:0]   i_amt,
  input  logic            i_sign,
  input  logic [W-1:0]    i_data,
  input  logic [TAGW-1:0] i_tag,
  output logic            o_valid,
  input  logic            i_ready,
  output shift_op_t       o_op,
  output logic [LW-1:0]   o_amt,
  output logic            o_sign,
  output logic [W-1:0]    o_data,
  output logic [TAGW-1:0] o_tag
);

  localparam int LO       = grp_lo(K, B);
  localparam int HI       = grp_hi(K, B, LW);
  localparam bit HAS_BITS = (LO < LW);

  logic            r_valid;
  shift_op_t       r_op;
  logic [LW-1:0]   r_amt;
  logic            r_sign;
  logic [W-1:0]    r_data;
  logic [TAGW-1:0] r_tag;

  logic [LW-1:0]   w_sh;
  logic [W-1:0]    w_res;
  logic [2*W-1:0]  w_dbl;
  logic [W-1:0]    w_fill;
  logic            w_load_en;

  // When STAGES does not divide the amount width evenly a trailing stage can
  // own no amount bits; it then behaves as a plain register slice.
  if (HAS_BITS) begin : g_amt
    // Place this stage's amount bits at their true weight.
    always_comb begin
      w_sh        = '0;
      w_sh[HI:LO] = i_amt[HI:LO];
    end
  end else begin : g_no_amt
    assign w_sh = '0;
  end

  // Partial shift for this stage. The sign fill uses the original operand
  // MSB carried from stage 0, not the current partial value.
  always_comb begin
    w_dbl  = {i_data, i_data} >> w_sh;
    w_fill = ~({W{1'b1}} >> w_sh);
    w_res  = i_data;
    case (i_op)
      SLL:     w_res = i_data << w_sh;
      SRL:     w_res = i_data >> w_sh;
      SRA:     w_res = (i_data >> w_sh) | (i_sign ? w_fill : '0);
      ROR:     w_res = w_dbl[W-1:0];
      default: w_res = i_data;
    endcase
  end

  // Load when empty or when the held entry leaves this cycle.
  assign w_load_en = ~r_valid | i_ready;
  assign o_ready   = w_load_en;

  // Occupancy bit; reset and flush both empty the stage.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_load_en) begin
      r_valid <= i_valid;
    end
  end

  // Payload register; unreset, only meaningful while r_valid is set.
  always_ff @(posedge i_clk) begin
    if (w_load_en && i_valid) begin
      r_op   <= i_op;
      r_amt  <= i_amt;
      r_sign <= i_sign;
      r_data <= w_res;
      r_tag  <= i_tag;
    end
  end

  assign o_valid = r_valid;
  assign o_op    = r_op;
  assign o_amt   = r_amt;
  assign o_sign  = r_sign;
  assign o_data  = r_data;
  assign o_tag   = r_tag;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined shifter / rotator with valid/ready on both sides. The shift
// amount is split into STAGES groups, LSB group first, one per stage.
module pipe_shifter
  import p_hardisc::*;
#(
  parameter int W      = 32,
  parameter int STAGES = 2,
  parameter int TAGW   = 4,
  localparam int LW    = $clog2(W)
) (
  input  logic            s_clk_i,
  input  logic            s_resetn_i,
  input  logic            s_flush_i,
  input  logic            s_valid_i,
  output logic            s_ready_o,
  input  shift_op_t       s_op_i,
  input  logic [LW-1:0]   s_amt_i,
  input  logic [W-1:0]    s_data_i,
  input  logic [TAGW-1:0] s_tag_i,
  output logic            s_valid_o,
  input  logic            s_ready_i,
  output logic [W-1:0]    s_data_o,
  output logic [TAGW-1:0] s_tag_o
);

  localparam int B = grp_bits(LW, STAGES);

  // Forward chain: index k feeds stage k, index STAGES is the output side.
  logic            w_valid [STAGES+1];
  shift_op_t       w_op    [STAGES+1];
  logic [LW-1:0]   w_amt   [STAGES+1];
  logic            w_sign  [STAGES+1];
  logic [W-1:0]    w_data  [STAGES+1];
  logic [TAGW-1:0] w_tag   [STAGES+1];
  logic            w_unused;

  assign w_valid[0] = s_valid_i;
  assign w_op[0]    = s_op_i;
  assign w_amt[0]   = s_amt_i;
  assign w_sign[0]  = s_data_i[W-1];
  assign w_data[0]  = s_data_i;
  assign w_tag[0]   = s_tag_i;

  // The ready chain runs backwards through per-stage nets so that each hop
  // is a distinct signal rather than a self-referencing array.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic w_rdy_up;
    logic w_rdy_dn;

    if (k == STAGES - 1) begin : g_last
      assign w_rdy_dn = s_ready_i;
    end else begin : g_mid
      assign w_rdy_dn = g_stg[k+1].w_rdy_up;
    end

    pipe_shift_stage #(
      .W    (W),
      .TAGW (TAGW),
      .K    (k),
      .B    (B)
    ) u_stage (
      .i_clk    (s_clk_i),
      .i_resetn (s_resetn_i),
      .i_flush  (s_flush_i),
      .i_valid  (w_valid[k]),
      .o_ready  (w_rdy_up),
      .i_op     (w_op[k]),
      .i_amt    (w_amt[k]),
      .i_sign   (w_sign[k]),
      .i_data   (w_data[k]),
      .i_tag    (w_tag[k]),
      .o_valid  (w_valid[k+1]),
      .i_ready  (w_rdy_dn),
      .o_op     (w_op[k+1]),
      .o_amt    (w_amt[k+1]),
      .o_sign   (w_sign[k+1]),
      .o_data   (w_data[k+1]),
      .o_tag    (w_tag[k+1])
    );
  end

  // A flush empties every stage, so the input side is free that cycle.
  assign s_ready_o = g_stg[0].w_rdy_up | s_flush_i;

  assign s_valid_o = w_valid[STAGES];
  assign s_data_o  = w_data[STAGES];
  assign s_tag_o   = w_tag[STAGES];

  // Sideband that only intermediate stages consume.
  assign w_unused = ^{w_op[STAGES], w_amt[STAGES], w_sign[STAGES]};

endmodule

// File: tb/tb_pipe_shifter.sv
module tb_pipe_shifter;
  import p_hardisc::*;

  localparam int W      = 32;
  localparam int STAGES = 2;
  localparam int TAGW   = 4;
  localparam int LW     = $clog2(W);

  typedef struct packed {
    logic [W-1:0]    d;
    logic [TAGW-1:0] t;
  } exp_t;

  logic            clk;
  logic            s_resetn_i;
  logic            s_flush_i;
  logic            s_valid_i;
  logic            s_ready_o;
  shift_op_t       s_op_i;
  logic [LW-1:0]   s_amt_i;
  logic [W-1:0]    s_data_i;
  logic [TAGW-1:0] s_tag_i;
  logic            s_valid_o;
  logic            s_ready_i;
  logic [W-1:0]    s_data_o;
  logic [TAGW-1:0] s_tag_o;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q[$];

  logic            acc, rdo, ofire, ovld;
  logic [W-1:0]    od;
  logic [TAGW-1:0] ot;

  pipe_shifter #(.W(W), .STAGES(STAGES), .TAGW(TAGW)) dut (
    .s_clk_i    (clk),
    .s_resetn_i (s_resetn_i),
    .s_flush_i  (s_flush_i),
    .s_valid_i  (s_valid_i),
    .s_ready_o  (s_ready_o),
    .s_op_i     (s_op_i),
    .s_amt_i    (s_amt_i),
    .s_data_i   (s_data_i),
    .s_tag_i    (s_tag_i),
    .s_valid_o  (s_valid_o),
    .s_ready_i  (s_ready_i),
    .s_data_o   (s_data_o),
    .s_tag_o    (s_tag_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Reference: each result bit picked directly from the operand.
  function automatic logic [W-1:0] ref_shift(input shift_op_t op, input logic [LW-1:0] amt,
                                             input logic [W-1:0] d);
    logic [W-1:0] r;
    int a;
    a = int'(amt);
    for (int i = 0; i < W; i++) begin
      case (op)
        SLL:     r[i] = (i >= a) ? d[i-a] : 1'b0;
        SRL:     r[i] = (i + a < W) ? d[i+a] : 1'b0;
        SRA:     r[i] = (i + a < W) ? d[i+a] : d[W-1];
        default: r[i] = d[(i + a) % W];
      endcase
    end
    return r;
  endfunction

  // Drive one cycle (called just after a falling edge), capture what the
  // handshakes look like before the rising edge, then advance to the next
  // falling edge. Accepted requests are queued with their expected result.
  task automatic step(input logic v, input shift_op_t op, input logic [LW-1:0] amt,
                      input logic [W-1:0] d, input logic [TAGW-1:0] tg,
                      input logic rdy, input logic fl);
    s_valid_i = v;
    s_op_i    = op;
    s_amt_i   = amt;
    s_data_i  = d;
    s_tag_i   = tg;
    s_ready_i = rdy;
    s_flush_i = fl;
    #1;
    rdo   = s_ready_o;
    acc   = v & s_ready_o;
    ovld  = s_valid_o;
    ofire = s_valid_o & rdy;
    od    = s_data_o;
    ot    = s_tag_o;
    if (acc && !fl && s_resetn_i) q.push_back('{d: ref_shift(op, amt, d), t: tg});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    s_resetn_i = 1'b0;
    step(1'b0, SLL, '0, '0, '0, 1'b0, 1'b0);
    step(1'b0, SLL, '0, '0, '0, 1'b0, 1'b0);
    s_resetn_i = 1'b1;
    q.delete();
    #1;
    total++;
    if (s_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%b exp=0", s_valid_o);
    end
    total++;
    if (s_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", s_ready_o);
    end
  endtask

  task automatic test_directed();
    shift_op_t       t_op  [8] = '{SLL, SRA, SRL, ROR, SLL, SRL, SRA, ROR};
    logic [LW-1:0]   t_amt [8] = '{5'd31, 5'd4, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [W-1:0]    t_in  [8] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_00F1,
                                   32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic [W-1:0]    t_exp [8] = '{32'h8000_0000, 32'hF800_0000, 32'h0800_0000, 32'h1000_000F,
                                   32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic [TAGW-1:0] t_tag [8] = '{4'h5, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, t_op[i], t_amt[i], t_in[i], t_tag[i], 1'b1, 1'b0);
      total++;
      if (acc !== 1'b1) begin
        bad++;
        $display("FAIL dir_accept vec=%0d got=%b exp=1", i, acc);
      end
      step(1'b0, SLL, '0, '0, '0, 1'b1, 1'b0);
      total++;
      if (ovld !== 1'b0) begin
        bad++;
        $display("FAIL dir_early vec=%0d valid got=%b exp=0", i, ovld);
      end
      step(1'b0, SLL, '0, '0, '0, 1'b1, 1'b0);
      total++;
      if (ofire !== 1'b1 || od !== t_exp[i] || ot !== t_tag[i]) begin
        bad++;
        $display("FAIL dir_result vec=%0d got v=%b d=%h t=%h exp v=1 d=%h t=%h",
                 i, ofire, od, ot, t_exp[i], t_tag[i]);
      end
      q.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n_out = 0;
    int   first = -1;
    int   last  = -1;
    for (int c = 0; c < 12; c++) begin
      step(c < 4, shift_op_t'($urandom_range(0, 3)), LW'($urandom), $urandom,
           TAGW'(c + 4), 1'b1, 1'b0);
      if (c < 4) begin
        total++;
        if (acc !== 1'b1) begin
          bad++;
          $display("FAIL b2b_accept idx=%0d got=%b exp=1", c, acc);
        end
      end
      if (ofire) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra got=%h/%h exp=no result", od, ot);
        end else begin
          e = q.pop_front();
          if (od !== e.d || ot !== e.t) begin
            bad++;
            $display("FAIL b2b_data got=%h/%h exp=%h/%h", od, ot, e.d, e.t);
          end
        end
        if (first < 0) first = c;
        last = c;
        n_out++;
      end
    end
    total++;
    if (n_out != 4 || first != 2 || last != 5) begin
      bad++;
      $display("FAIL b2b_timing got n=%0d first=%0d last=%0d exp n=4 first=2 last=5",
               n_out, first, last);
    end
  endtask

  task automatic test_stall();
    shift_op_t       p_op  [4];
    logic [LW-1:0]   p_amt [4];
    logic [W-1:0]    p_d   [4];
    exp_t            e;
    int              sent = 0;
    int              got  = 0;
    logic            hold = 1'b0;
    logic [W-1:0]    h_d;
    logic [TAGW-1:0] h_t;
    logic            r;
    for (int i = 0; i < 4; i++) begin
      p_op[i]  = shift_op_t'($urandom_range(0, 3));
      p_amt[i] = LW'($urandom);
      p_d[i]   = $urandom;
    end
    for (int c = 0; c < 30 && got < 4; c++) begin
      r = (c >= 5);
      if (sent < 4) step(1'b1, p_op[sent], p_amt[sent], p_d[sent], TAGW'(sent + 1), r, 1'b0);
      else          step(1'b0, SLL, '0, '0, '0, r, 1'b0);
      if (hold) begin
        total++;
        if (ovld !== 1'b1 || od !== h_d || ot !== h_t) begin
          bad++;
          $display("FAIL stall_hold cyc=%0d got v=%b d=%h t=%h exp v=1 d=%h t=%h",
                   c, ovld, od, ot, h_d, h_t);
        end
      end
      hold = ovld & ~r;
      h_d  = od;
      h_t  = ot;
      if (acc) sent++;
      if (c >= 2 && c <= 4) begin
        total++;
        if (rdo !== 1'b0) begin
          bad++;
          $display("FAIL stall_ready cyc=%0d got=%b exp=0", c, rdo);
        end
      end
      if (c == 4) begin
        total++;
        if (sent != 2) begin
          bad++;
          $display("FAIL stall_accepted got=%0d exp=2", sent);
        end
      end
      if (ofire) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL stall_extra got=%h/%h exp=no result", od, ot);
        end else begin
          e = q.pop_front();
          if (od !== e.d || ot !== e.t) begin
            bad++;
            $display("FAIL stall_data got=%h/%h exp=%h/%h", od, ot, e.d, e.t);
          end
        end
        got++;
      end
    end
    total++;
    if (got != 4 || q.size() != 0) begin
      bad++;
      $display("FAIL stall_drain got=%0d left=%0d exp=4 left=0", got, q.size());
    end
  endtask

  task automatic test_flush();
    int           n_out = 0;
    logic [W-1:0] d_new;
    d_new = $urandom;
    step(1'b1, SLL, 5'd1, 32'h1111_1111, 4'h1, 1'b0, 1'b0);
    step(1'b1, SRL, 5'd2, 32'h2222_2222, 4'h2, 1'b0, 1'b0);
    step(1'b1, ROR, 5'd3, 32'h3333_3333, 4'h3, 1'b0, 1'b1);
    total++;
    if (rdo !== 1'b1) begin
      bad++;
      $display("FAIL flush_ready got=%b exp=1", rdo);
    end
    q.delete();
    step(1'b0, SLL, '0, '0, '0, 1'b1, 1'b0);
    total++;
    if (ovld !== 1'b0) begin
      bad++;
      $display("FAIL flush_valid got=%b exp=0", ovld);
    end
    step(1'b1, SRA, 5'd7, d_new, 4'hC, 1'b1, 1'b0);
    for (int c = 1; c < 7; c++) begin
      step(1'b0, SLL, '0, '0, '0, 1'b1, 1'b0);
      if (ofire) begin
        n_out++;
        total++;
        if (c != 2 || od !== ref_shift(SRA, 5'd7, d_new) || ot !== 4'hC) begin
          bad++;
          $display("FAIL flush_after cyc=%0d got=%h/%h exp=%h/c at cyc 2",
                   c, od, ot, ref_shift(SRA, 5'd7, d_new));
        end
      end
    end
    q.delete();
    total++;
    if (n_out != 1) begin
      bad++;
      $display("FAIL flush_count got=%0d exp=1", n_out);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, SLL, 5'd3, $urandom, 4'h6, 1'b0, 1'b0);
    step(1'b1, SRL, 5'd5, $urandom, 4'h7, 1'b0, 1'b0);
    s_resetn_i = 1'b0;
    step(1'b0, SLL, '0, '0, '0, 1'b0, 1'b0);
    s_resetn_i = 1'b1;
    q.delete();
    #1;
    total++;
    if (s_valid_o !== 1'b0 || s_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_state got v=%b r=%b exp v=0 r=1", s_valid_o, s_ready_o);
    end
    for (int c = 0; c < 5; c++) begin
      step(1'b0, SLL, '0, '0, '0, 1'b1, 1'b0);
      total++;
      if (ofire !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_stale cyc=%0d got=%h/%h exp=no result", c, od, ot);
      end
    end
  endtask

  task automatic test_random();
    exp_t            e;
    logic            hold = 1'b0;
    logic [W-1:0]    h_d;
    logic [TAGW-1:0] h_t;
    logic            r, fl;
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(0, 99) < 70);
      fl = ($urandom_range(0, 99) < 2);
      step($urandom_range(0, 99) < 65, shift_op_t'($urandom_range(0, 3)), LW'($urandom),
           $urandom, TAGW'($urandom), r, fl);
      if (hold) begin
        total++;
        if (ovld !== 1'b1 || od !== h_d || ot !== h_t) begin
          bad++;
          $display("FAIL rand_hold cyc=%0d got v=%b d=%h t=%h exp v=1 d=%h t=%h",
                   c, ovld, od, ot, h_d, h_t);
        end
      end
      hold = ovld & ~r & ~fl;
      h_d  = od;
      h_t  = ot;
      if (ofire) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rand_extra cyc=%0d got=%h/%h exp=no result", c, od, ot);
        end else begin
          e = q.pop_front();
          if (od !== e.d || ot !== e.t) begin
            bad++;
            $display("FAIL rand_data cyc=%0d got=%h/%h exp=%h/%h", c, od, ot, e.d, e.t);
          end
        end
      end
      if (fl) q.delete();
    end
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      step(1'b0, SLL, '0, '0, '0, 1'b1, 1'b0);
      if (ofire) begin
        e = q.pop_front();
        total++;
        if (od !== e.d || ot !== e.t) begin
          bad++;
          $display("FAIL rand_drain got=%h/%h exp=%h/%h", od, ot, e.d, e.t);
        end
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL rand_timeout left got=%0d exp=0", q.size());
    end
  endtask

  initial begin
    s_resetn_i = 1'b0;
    s_flush_i  = 1'b0;
    s_valid_i  = 1'b0;
    s_op_i     = SLL;
    s_amt_i    = '0;
    s_data_i   = '0;
    s_tag_i    = '0;
    s_ready_i  = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
